// File: rtl/crank_decoder.sv
// Missing-tooth crank wheel decoder: synchronises the sensor input, measures the time
// between teeth, finds the gap and tracks the absolute tooth index.
module crank_decoder #(
    parameter int unsigned TEETH_TOTAL   = 60,
    parameter int unsigned TEETH_MISSING = 2,
    parameter int unsigned PERIOD_W      = 20
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                vrin,
    output logic                tooth_strobe,
    output logic [5:0]          tooth_index,
    output logic [PERIOD_W-1:0] tooth_period,
    output logic                synced,
    output logic                sync_loss
);

    localparam logic [5:0]          LastIndex = 6'(TEETH_TOTAL - TEETH_MISSING - 1);
    localparam logic [PERIOD_W-1:0] PeriodMax = '1;

    typedef enum logic [1:0] {StIdle, StFirst, StHunt, StSynced} state_e;

    logic                sync1_q, sync2_q, sync3_q;
    logic [1:0]          fill_q;
    logic                armed_q;
    logic                tooth_q;

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] prev_q, prev_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [5:0]          index_q, index_d;
    state_e              state_q, state_d;
    logic                synced_q, synced_d;
    logic                strobe_q, strobe_d;
    logic                loss_q, loss_d;

    logic                stall;
    logic                gap;
    logic                lose;
    logic [PERIOD_W+1:0] period_x2;
    logic [PERIOD_W+1:0] prev_x3;

    // Edges are only accepted once the synchronised input has been seen low after reset,
    // so a sensor already high at reset release does not count as a tooth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            fill_q  <= 2'd0;
            armed_q <= 1'b0;
            tooth_q <= 1'b0;
        end else begin
            sync1_q <= vrin;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
            if (fill_q == 2'd2 && !sync2_q) begin
                armed_q <= 1'b1;
            end
            tooth_q <= sync2_q & ~sync3_q & armed_q;
        end
    end

    assign period_x2 = {1'b0, cnt_q, 1'b0};
    assign prev_x3   = {2'b00, prev_q} + {1'b0, prev_q, 1'b0};
    assign gap       = period_x2 > prev_x3;
    assign stall     = !tooth_q && (cnt_q == PeriodMax);

    // Counter restarts at 1 on a tooth so that it holds the full tooth spacing at the next one.
    always_comb begin
        if (tooth_q) begin
            cnt_d = PERIOD_W'(1);
        end else if (cnt_q == PeriodMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        synced_d = synced_q;
        period_d = period_q;
        prev_d   = prev_q;
        strobe_d = 1'b0;
        loss_d   = 1'b0;
        lose     = 1'b0;

        if (tooth_q) begin
            strobe_d = 1'b1;
            period_d = cnt_q;
            prev_d   = cnt_q;
            case (state_q)
                StIdle:  state_d = StFirst;
                StFirst: state_d = StHunt;
                StHunt: begin
                    if (gap) begin
                        state_d  = StSynced;
                        synced_d = 1'b1;
                        index_d  = 6'd0;
                    end
                end
                StSynced: begin
                    // The gap must land exactly after the last present tooth.
                    if (index_q == LastIndex) begin
                        if (gap) begin
                            index_d = 6'd0;
                        end else begin
                            lose = 1'b1;
                        end
                    end else if (gap) begin
                        lose = 1'b1;
                    end else begin
                        index_d = index_q + 6'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (lose) begin
                state_d  = StHunt;
                synced_d = 1'b0;
                index_d  = 6'd0;
                loss_d   = 1'b1;
            end
        end else if (stall) begin
            state_d  = StIdle;
            synced_d = 1'b0;
            index_d  = 6'd0;
            loss_d   = synced_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            prev_q   <= '0;
            period_q <= '0;
            index_q  <= 6'd0;
            state_q  <= StIdle;
            synced_q <= 1'b0;
            strobe_q <= 1'b0;
            loss_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            period_q <= period_d;
            index_q  <= index_d;
            state_q  <= state_d;
            synced_q <= synced_d;
            strobe_q <= strobe_d;
            loss_q   <= loss_d;
        end
    end

    assign tooth_strobe = strobe_q;
    assign tooth_index  = index_q;
    assign tooth_period = period_q;
    assign synced       = synced_q;
    assign sync_loss    = loss_q;

endmodule
